// File: rtl/frame_src_arbiter_if.sv
// Frame beat bundle: one valid/ready handshake carrying data plus
// start/end-of-frame and start/end-of-line markers.
interface frame_src_arbiter_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic                  frm_val;
    logic                  frm_rdy;
    logic [DATA_WIDTH-1:0] frm_data;
    logic                  frm_sof;
    logic                  frm_eof;
    logic                  frm_sol;
    logic                  frm_eol;

    modport master (
        output frm_val, frm_data, frm_sof, frm_eof, frm_sol, frm_eol,
        input  frm_rdy
    );

    modport slave (
        input  frm_val, frm_data, frm_sof, frm_eof, frm_sol, frm_eol,
        output frm_rdy
    );
endinterface

// File: rtl/frame_src_arbiter.sv
// Two-source frame arbiter: grants the downstream pipe for whole frames,
// round-robin between sources, flushes orphan beats and checks line count.
module frame_src_arbiter #(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          cfg_img_h,
    input  logic [1:0]           cfg_src_en,
    input  logic                 err_clr,
    frame_src_arbiter_if.slave   m0,
    frame_src_arbiter_if.slave   m1,
    frame_src_arbiter_if.master  s,
    output logic                 sts_busy,
    output logic                 sts_grant,
    output logic [CNT_WIDTH-1:0] sts_frm_cnt,
    output logic [CNT_WIDTH-1:0] sts_drop_cnt,
    output logic                 sts_err_lines,
    output logic                 sts_err_sof
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic                  grant_reg, grant_next;
    logic                  rr_last_reg, rr_last_next;
    logic                  first_reg, first_next;
    logic [11:0]           line_cnt_reg, line_cnt_next;
    logic [CNT_WIDTH-1:0]  frm_cnt_reg, frm_cnt_next;
    logic [CNT_WIDTH-1:0]  drop_cnt_reg, drop_cnt_next;
    logic                  err_lines_reg, err_lines_next;
    logic                  err_sof_reg, err_sof_next;

    logic [1:0]            src_val, src_sof, src_eof, src_sol, src_eol;
    logic [1:0]            src_req, src_flush, src_rdy;
    logic [DATA_WIDTH-1:0] src_data [2];

    logic                  pass;
    logic                  beat_xfer;
    logic [11:0]           line_sum;
    logic                  set_err_lines, set_err_sof;

    assign src_val     = {m1.frm_val, m0.frm_val};
    assign src_sof     = {m1.frm_sof, m0.frm_sof};
    assign src_eof     = {m1.frm_eof, m0.frm_eof};
    assign src_sol     = {m1.frm_sol, m0.frm_sol};
    assign src_eol     = {m1.frm_eol, m0.frm_eol};
    assign src_data[0] = m0.frm_data;
    assign src_data[1] = m1.frm_data;
    assign m0.frm_rdy  = src_rdy[0];
    assign m1.frm_rdy  = src_rdy[1];

    assign pass = (state_reg == ST_PASS);

    // Handshakes are suppressed while reset is held so no beat is consumed
    // by a cycle whose effect is about to be discarded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_req[gi]   = cfg_src_en[gi] & src_val[gi] & src_sof[gi];
            assign src_flush[gi] = ~rst & ~pass & cfg_src_en[gi] & src_val[gi] & ~src_sof[gi];
            assign src_rdy[gi]   = src_flush[gi] |
                                   (~rst & pass & (grant_reg == 1'(gi)) & s.frm_rdy);
        end
    endgenerate

    assign s.frm_val  = ~rst & pass & src_val[grant_reg];
    assign s.frm_data = pass ? src_data[grant_reg] : '0;
    assign s.frm_sof  = pass & src_sof[grant_reg];
    assign s.frm_eof  = pass & src_eof[grant_reg];
    assign s.frm_sol  = pass & src_sol[grant_reg];
    assign s.frm_eol  = pass & src_eol[grant_reg];

    assign beat_xfer = pass & src_val[grant_reg] & s.frm_rdy;
    assign line_sum  = line_cnt_reg + 12'(src_eol[grant_reg]);

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        rr_last_next  = rr_last_reg;
        first_next    = first_reg;
        line_cnt_next = line_cnt_reg;
        frm_cnt_next  = frm_cnt_reg;
        drop_cnt_next = drop_cnt_reg + CNT_WIDTH'(src_flush[0]) + CNT_WIDTH'(src_flush[1]);
        set_err_lines = 1'b0;
        set_err_sof   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|src_req) begin
                    state_next = ST_PASS;
                    grant_next = (&src_req) ? ~rr_last_reg : src_req[1];
                    first_next = 1'b1;
                end
            end
            ST_PASS: begin
                if (beat_xfer) begin
                    first_next = 1'b0;
                    if (src_sof[grant_reg] && !first_reg) begin
                        set_err_sof = 1'b1;
                    end
                    if (src_eof[grant_reg]) begin
                        set_err_lines = (line_sum != cfg_img_h);
                        line_cnt_next = '0;
                        frm_cnt_next  = frm_cnt_reg + 1'b1;
                        rr_last_next  = grant_reg;
                        state_next    = ST_IDLE;
                    end else if (src_eol[grant_reg]) begin
                        line_cnt_next = line_sum;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A fresh error in the same cycle as a clear must survive.
        err_lines_next = set_err_lines | (err_lines_reg & ~err_clr);
        err_sof_next   = set_err_sof   | (err_sof_reg   & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= 1'b0;
            rr_last_reg   <= 1'b1;
            first_reg     <= 1'b0;
            line_cnt_reg  <= '0;
            frm_cnt_reg   <= '0;
            drop_cnt_reg  <= '0;
            err_lines_reg <= 1'b0;
            err_sof_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_last_reg   <= rr_last_next;
            first_reg     <= first_next;
            line_cnt_reg  <= line_cnt_next;
            frm_cnt_reg   <= frm_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
            err_lines_reg <= err_lines_next;
            err_sof_reg   <= err_sof_next;
        end
    end

    assign sts_busy      = pass;
    assign sts_grant     = grant_reg;
    assign sts_frm_cnt   = frm_cnt_reg;
    assign sts_drop_cnt  = drop_cnt_reg;
    assign sts_err_lines = err_lines_reg;
    assign sts_err_sof   = err_sof_reg;

endmodule

// File: tb/tb_frame_src_arbiter.sv
// Bench for frame_src_arbiter: queued frame sources, a frame-ownership
// reference model checked every cycle, and directed literal expectations.
module tb_frame_src_arbiter;
    localparam int DW = 24;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [11:0]   cfg_img_h = 12'd3;
    logic [1:0]    cfg_src_en = 2'b00;
    logic          err_clr = 1'b0;
    logic          sts_busy, sts_grant, sts_err_lines, sts_err_sof;
    logic [CW-1:0] sts_frm_cnt, sts_drop_cnt;

    frame_src_arbiter_if #(.DATA_WIDTH(DW)) mi0 ();
    frame_src_arbiter_if #(.DATA_WIDTH(DW)) mi1 ();
    frame_src_arbiter_if #(.DATA_WIDTH(DW)) si ();

    frame_src_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cfg_img_h(cfg_img_h), .cfg_src_en(cfg_src_en),
        .err_clr(err_clr), .m0(mi0), .m1(mi1), .s(si),
        .sts_busy(sts_busy), .sts_grant(sts_grant), .sts_frm_cnt(sts_frm_cnt),
        .sts_drop_cnt(sts_drop_cnt), .sts_err_lines(sts_err_lines), .sts_err_sof(sts_err_sof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic sof, eof, sol, eol;
    } beat_t;

    beat_t q0[$], q1[$];
    bit [1:0] vld, cap_rdy;
    int  pval = 100, prdy = 100, rclr_pct = 0;
    bit  clr_on_eof = 0;
    int  acc[2];
    int  n_out = 0, seq = 0;
    int  n_chk = 0, n_fail = 0;
    int  gq[$];

    // Reference model: who owns the downstream, and the status it implies.
    int  own = -1, rr = 1, gr = 0, lines = 0, frm = 0, drop = 0;
    bit  mfirst = 0, el = 0, es = 0, mvalid = 0;
    beat_t nb[2], e_s;
    bit [1:0] nv, e_rdy;
    bit e_sval, sr, sl, ss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        nb[0] = {mi0.frm_data, mi0.frm_sof, mi0.frm_eof, mi0.frm_sol, mi0.frm_eol};
        nb[1] = {mi1.frm_data, mi1.frm_sof, mi1.frm_eof, mi1.frm_sol, mi1.frm_eol};
        nv    = {mi1.frm_val, mi0.frm_val};
        sr    = si.frm_rdy;
        e_rdy = 2'b00; e_sval = 1'b0; e_s = '0;
        if (own < 0) begin
            for (int i = 0; i < 2; i++)
                e_rdy[i] = cfg_src_en[i] && nv[i] && !nb[i].sof;
        end else begin
            e_s        = nb[own];
            e_sval     = nv[own];
            e_rdy[own] = sr;
        end
        if (rst) begin
            e_rdy = 2'b00; e_sval = 1'b0;
        end
        cap_rdy = {mi1.frm_rdy, mi0.frm_rdy};

        if (mvalid) begin
            chk("s_val", si.frm_val, e_sval);
            chk("s_beat", {si.frm_data, si.frm_sof, si.frm_eof, si.frm_sol, si.frm_eol}, e_s);
            chk("m0_rdy", mi0.frm_rdy, e_rdy[0]);
            chk("m1_rdy", mi1.frm_rdy, e_rdy[1]);
            chk("busy", sts_busy, own >= 0);
            chk("grant", sts_grant, gr);
            chk("frm_cnt", sts_frm_cnt, frm % 65536);
            chk("drop_cnt", sts_drop_cnt, drop % 65536);
            chk("err_lines", sts_err_lines, el);
            chk("err_sof", sts_err_sof, es);
            if (si.frm_val && sr) begin
                n_out++;
                if (own >= 0 && mfirst) gq.push_back(int'(sts_grant));
            end
        end

        if (rst) begin
            own = -1; rr = 1; gr = 0; lines = 0; frm = 0; drop = 0;
            el = 0; es = 0; mfirst = 0; mvalid = 1;
        end else begin
            sl = 0; ss = 0;
            if (own < 0) begin
                drop += int'(e_rdy[0]) + int'(e_rdy[1]);
                if (cfg_src_en[0] && nv[0] && nb[0].sof && cfg_src_en[1] && nv[1] && nb[1].sof)
                    own = 1 - rr;
                else if (cfg_src_en[0] && nv[0] && nb[0].sof)
                    own = 0;
                else if (cfg_src_en[1] && nv[1] && nb[1].sof)
                    own = 1;
                if (own >= 0) begin gr = own; mfirst = 1; end
            end else if (nv[own] && sr) begin
                if (nb[own].sof && !mfirst) ss = 1;
                mfirst = 0;
                if (nb[own].eof) begin
                    if (((lines + int'(nb[own].eol)) % 4096) != int'(cfg_img_h)) sl = 1;
                    lines = 0; frm++; rr = own; own = -1;
                end else if (nb[own].eol) begin
                    lines = (lines + 1) % 4096;
                end
            end
            el = sl || (el && !err_clr);
            es = ss || (es && !err_clr);
        end
    end

    task automatic drive();
        beat_t b0, b1;
        b0 = '0; b1 = '0;
        if (vld[0] && q0.size() > 0) b0 = q0[0];
        if (vld[1] && q1.size() > 0) b1 = q1[0];
        mi0.frm_val = vld[0];
        {mi0.frm_data, mi0.frm_sof, mi0.frm_eof, mi0.frm_sol, mi0.frm_eol} = b0;
        mi1.frm_val = vld[1];
        {mi1.frm_data, mi1.frm_sof, mi1.frm_eof, mi1.frm_sol, mi1.frm_eol} = b1;
    endtask

    task automatic tick();
        beat_t f;
        @(posedge clk); #1;
        if (vld[0] && cap_rdy[0]) begin void'(q0.pop_front()); acc[0]++; vld[0] = 0; end
        if (vld[1] && cap_rdy[1]) begin void'(q1.pop_front()); acc[1]++; vld[1] = 0; end
        if (!vld[0] && q0.size() > 0 && $urandom_range(99) < pval) vld[0] = 1;
        if (!vld[1] && q1.size() > 0 && $urandom_range(99) < pval) vld[1] = 1;
        si.frm_rdy = ($urandom_range(99) < prdy);
        if (clr_on_eof) begin
            f = '0;
            if (vld[0]) f = q0[0];
            err_clr = f.eof;
        end else if (rclr_pct > 0) begin
            err_clr = ($urandom_range(99) < rclr_pct);
        end
        drive();
    endtask

    task automatic push_beat(input int src, input beat_t b);
        if (src == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic push_frame(input int src, input int w, input int h,
                              input int miss_eol_line, input int sof_at);
        beat_t b;
        for (int l = 0; l < h; l++) begin
            for (int c = 0; c < w; c++) begin
                b.data = {src[0], 23'(seq)};
                seq++;
                b.sof  = (l == 0 && c == 0) || (l * w + c == sof_at);
                b.eof  = (l == h - 1) && (c == w - 1);
                b.sol  = (c == 0);
                b.eol  = (c == w - 1) && (l != miss_eol_line);
                push_beat(src, b);
            end
        end
    endtask

    task automatic push_orph(input int src, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b = '0;
            b.data = {src[0], 23'(seq)};
            seq++;
            push_beat(src, b);
        end
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete(); vld = 0; err_clr = 0; drive();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || vld != 0 || own >= 0) && n < budget) begin
            tick(); n++;
        end
        chk({name, "_done_in_budget"}, n < budget, 1);
        tick(); tick();
    endtask

    initial begin
        int n0, n;
        si.frm_rdy = 1'b1;
        drive();

        // Reset state
        do_reset(); #1;
        chk("rst_busy", sts_busy, 0);
        chk("rst_grant", sts_grant, 0);
        chk("rst_frm_cnt", sts_frm_cnt, 0);
        chk("rst_drop_cnt", sts_drop_cnt, 0);
        chk("rst_err", {sts_err_lines, sts_err_sof}, 0);

        // One 4x3 frame from source 0
        cfg_img_h = 3; cfg_src_en = 2'b01; prdy = 100; pval = 100;
        n0 = n_out;
        push_frame(0, 4, 3, -1, -1);
        wait_idle("t1", 200);
        chk("t1_beats", n_out - n0, 12);
        chk("t1_frm_cnt", sts_frm_cnt, 1);
        chk("t1_err", {sts_err_lines, sts_err_sof}, 0);

        // Both sources: grants alternate
        do_reset();
        cfg_img_h = 2; cfg_src_en = 2'b11; gq.delete();
        for (int k = 0; k < 2; k++) begin
            push_frame(0, 2, 2, -1, -1);
            push_frame(1, 2, 2, -1, -1);
        end
        wait_idle("t2", 300);
        chk("t2_frm_cnt", sts_frm_cnt, 4);
        chk("t2_ngrants", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("t2_g0", gq[0], 0); chk("t2_g1", gq[1], 1);
            chk("t2_g2", gq[2], 0); chk("t2_g3", gq[3], 1);
        end

        // Orphan flush on source 1
        do_reset();
        cfg_img_h = 2; cfg_src_en = 2'b10;
        push_orph(1, 5);
        push_frame(1, 2, 2, -1, -1);
        wait_idle("t3", 200);
        chk("t3_drop_cnt", sts_drop_cnt, 5);
        chk("t3_frm_cnt", sts_frm_cnt, 1);

        // Line-count error, clear, and clear colliding with a new error
        do_reset();
        cfg_img_h = 3; cfg_src_en = 2'b01;
        push_frame(0, 4, 3, 1, -1);
        wait_idle("t4a", 200);
        chk("t4_err_set", sts_err_lines, 1);
        err_clr = 1; tick(); err_clr = 0; tick();
        chk("t4_err_cleared", sts_err_lines, 0);
        clr_on_eof = 1;
        push_frame(0, 4, 3, 1, -1);
        wait_idle("t4b", 200);
        clr_on_eof = 0; err_clr = 0;
        chk("t4_set_wins", sts_err_lines, 1);

        // Random downstream backpressure with a stray sof mid-frame
        do_reset();
        cfg_img_h = 3; cfg_src_en = 2'b01; prdy = 50;
        n0 = n_out;
        push_frame(0, 3, 3, -1, 4);
        wait_idle("t5", 400);
        chk("t5_beats", n_out - n0, 9);
        chk("t5_err_sof", sts_err_sof, 1);
        chk("t5_err_lines", sts_err_lines, 0);
        prdy = 100;

        // Reset during the third beat of a source 1 frame
        do_reset();
        cfg_img_h = 3; cfg_src_en = 2'b10; acc[1] = 0;
        push_frame(1, 4, 3, -1, -1);
        n = 0;
        while (acc[1] < 2 && n < 100) begin tick(); n++; end
        chk("t6_reach_beat3", acc[1], 2);
        rst = 1; tick();
        q1.delete(); vld = 0; rst = 0; drive(); #1;
        chk("t6_s_val", si.frm_val, 0);
        chk("t6_busy", sts_busy, 0);
        chk("t6_grant", sts_grant, 0);
        chk("t6_frm_cnt", sts_frm_cnt, 0);
        chk("t6_m1_rdy", mi1.frm_rdy, 0);
        cfg_src_en = 2'b11; gq.delete();
        push_frame(1, 2, 3, -1, -1);
        push_frame(0, 2, 3, -1, -1);
        wait_idle("t6", 200);
        chk("t6_first_grant", gq.size() > 0 ? gq[0] : -1, 0);
        chk("t6_frm_after", sts_frm_cnt, 2);

        // Randomized traffic against the model
        do_reset();
        cfg_img_h = 2; cfg_src_en = 2'b11; prdy = 70; pval = 70; rclr_pct = 3;
        for (int k = 0; k < 40; k++) begin
            int src, w, h, miss, sat;
            src = $urandom_range(1);
            w = $urandom_range(4, 1);
            h = $urandom_range(3, 1);
            miss = ($urandom_range(5) == 0) ? $urandom_range(h - 1) : -1;
            sat = (w * h > 1 && $urandom_range(7) == 0) ? $urandom_range(w * h - 1, 1) : -1;
            if ($urandom_range(4) == 0) push_orph(src, $urandom_range(3, 1));
            push_frame(src, w, h, miss, sat);
        end
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || vld != 0 || own >= 0) && n < 20000) begin
            tick(); n++;
            if (n % 37 == 0) cfg_src_en = (n > 6000) ? 2'b11 : 2'($urandom_range(3));
        end
        chk("rand_done_in_budget", n < 20000, 1);
        rclr_pct = 0; err_clr = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/frame_src_arbiter.md
Name: frame_src_arbiter

Overview:
- Two-input frame-interface arbiter. It shares one downstream frame pipeline between two frame sources, for example raw IR capture and a filtered stream.
- Ownership is granted per whole frame, so a frame is never interleaved with the other source.
- Within a frame the data path is a zero-latency combinational mux.
- Mid-frame orphan beats are flushed, and frame geometry is checked against the configured image height.

Parameters:
DATA_WIDTH, 24, frame data width in bits
CNT_WIDTH, 16, width of status frame/drop counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cfg_img_h  input  12  expected lines per frame
cfg_src_en  input  2  per-source enable; bit i enables source i
err_clr  input  1  clears sticky error flags
m0_frm_val  input  1  source 0 beat valid
m0_frm_rdy  output  1  source 0 beat accepted
m0_frm_data  input  DATA_WIDTH  source 0 data
m0_frm_sof / m0_frm_eof / m0_frm_sol / m0_frm_eol  input  1 each  source 0 framing
m1_frm_val / m1_frm_rdy / m1_frm_data / m1_frm_sof / m1_frm_eof / m1_frm_sol / m1_frm_eol  same as source 0, for source 1
s_frm_val  output  1  downstream valid
s_frm_rdy  input  1  downstream ready
s_frm_data  output  DATA_WIDTH  downstream data
s_frm_sof / s_frm_eof / s_frm_sol / s_frm_eol  output  1 each  downstream framing
sts_busy  output  1  1 while a frame is being passed
sts_grant  output  1  index of current/last granted source
sts_frm_cnt  output  CNT_WIDTH  frames completed, wraps
sts_drop_cnt  output  CNT_WIDTH  orphan beats flushed, wraps
sts_err_lines  output  1  sticky: frame line count != cfg_img_h
sts_err_sof  output  1  sticky: sof seen inside a granted frame

Behaviour:
- Beat transfer on any port: val & rdy in the same cycle.
- Reset: state=IDLE, rr_last=1 (so source 0 wins first), line_cnt=0, all status outputs 0, sts_grant=0.
- Reset asserted mid-frame aborts the frame; no completion is counted.
- IDLE state:
  - s_frm_val=0.
  - Request req_i = cfg_src_en[i] & mi_frm_val & mi_frm_sof.
  - If both request, the winner is the source != rr_last; otherwise the single requester wins.
  - Grant is registered: move to PASS next cycle, and sts_grant updates in that cycle. Winner's rdy stays 0 in IDLE, so its sof beat is held.
  - An enabled source with val=1 and sof=0 is an orphan: rdy=1 (flushed), sts_drop_cnt+1 per flushed beat.
  - Disabled sources: rdy=0 always.
- PASS state (source g):
  - s_frm_val/data/sof/eof/sol/eol = mg_*; mg_frm_rdy = s_frm_rdy; the other source's rdy=0.
  - Data path has zero latency; no registers in the data path.
  - line_cnt (12 bit) increments on each transferred beat with eol.
  - Transferred beat with sof that is not the first beat of the frame sets sts_err_sof.
  - Transferred beat with eof: compare (line_cnt + eol) against cfg_img_h; mismatch sets sts_err_lines. Then line_cnt=0, sts_frm_cnt+1, rr_last=g, and state returns to IDLE next cycle.
  - A beat with eof=1 and sof=1 is a valid one-beat frame.
- Clearing cfg_src_en[g] during PASS does not abort; the frame finishes. The source is excluded from the next arbitration.
- err_clr clears both sticky flags. If a set condition and err_clr occur in the same cycle, set wins.
- Counters wrap modulo 2^CNT_WIDTH; line_cnt wraps at 4096.
- sts_busy = (state==PASS).
- Minimum gap between frames is 1 IDLE cycle (arbitration).

Test Plan:
- Src0 only enabled, one 4x3 frame (cfg_img_h=3), s_frm_rdy=1 -> 12 beats out in order, sof on beat 0, eof on beat 11, sts_frm_cnt=1, no errors, s_frm_data equals m0 data in the same cycle.
- Both sources continuously offer 2x2 frames starting with sof -> grants alternate 0,1,0,1; no interleaving within any frame; sts_frm_cnt=4 after four frames.
- Src1 drives 5 beats without sof while IDLE, then a sof frame -> the 5 beats are flushed with m1_frm_rdy=1, sts_drop_cnt=5, then the frame passes intact.
- cfg_img_h=3, src0 frame with only 2 eol beats before eof -> sts_err_lines=1 after the eof beat; err_clr pulse -> 0; a simultaneous error and err_clr leaves the flag at 1.
- s_frm_rdy toggled randomly at 50% during a frame -> source rdy mirrors s_frm_rdy; no beat lost or duplicated; sof inside the frame sets sts_err_sof.
- rst pulsed on the 3rd beat of a src1 frame -> all outputs 0 in the next cycle; a new src0 sof frame is granted first and passes normally.
